// File: rtl/input_debouncer.sv
//----------------------------------------------------------------------------
// input_debouncer: synchronizes and debounces a raw input; emits level + edge pulses.
// Optional macro DEBOUNCE_FALL_PULSE_EN builds the fall pulse (else fall_o = 0).
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   commit_w;
  logic                   sync_s_w;

  assign sync_s_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    rise_d   = 1'b0;
    commit_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_s_w != dout_q) begin
          if (STABLE_CYCLES == 1) begin
            commit_w = 1'b1;
          end else begin
            state_d = COUNT;
            cnt_d   = C_CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      COUNT: begin
        // Any sample back at the current level rejects the candidate.
        if (sync_s_w == dout_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          commit_w = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (commit_w) begin
      dout_d  = sync_s_w;
      rise_d  = sync_s_w;
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= commit_w & ~sync_s_w;
    end
  end
  assign fall_o = fall_q;
`else
  assign fall_o = 1'b0;
`endif

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign busy_o = (state_q == COUNT);

endmodule

`default_nettype wire
